// File: rtl/hh_counter24.sv
// Hour registers (clock and alarm, BCD 00-23) with a selectable two-digit display,
// a day-wrap carry pulse and a timed alarm-ring FSM.
module hh_counter24 #(
    parameter int RING_CYCLES = 1000,
    parameter int RING_W      = 16
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       up_clock24,
    input  logic       up_alarm24,
    input  logic       clock_alarm,
    input  logic       alarm_en,
    input  logic       alarm_off,
    output logic [1:0] hh_tens,
    output logic [3:0] hh_units,
    output logic       carry_24,
    output logic       alarm_ring
);

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } state_t;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_CYCLES - 1);

    // Hours are packed {tens[1:0], units[3:0]}, so 23 is 6'h23 in BCD
    function automatic logic [5:0] inc_hour(input logic [5:0] h);
        logic [5:0] r;
        if (h == 6'h23) begin
            r = 6'h00;
        end else if (h[3:0] == 4'd9) begin
            r = {h[5:4] + 2'd1, 4'd0};
        end else begin
            r = {h[5:4], h[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic [5:0]        clk_hh_q, clk_hh_d;
    logic [5:0]        alm_hh_q, alm_hh_d;
    logic [5:0]        clk_inc_s, alm_inc_s, disp_s;
    logic              carry_q, carry_d;
    state_t            state_q, state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic              trigger_s;

    // Hour register next-state, carry detection and display select
    always_comb begin
        clk_inc_s = inc_hour(clk_hh_q);
        alm_inc_s = inc_hour(alm_hh_q);
        if (up_clock24) begin
            clk_hh_d = clk_inc_s;
        end else begin
            clk_hh_d = clk_hh_q;
        end
        if (up_alarm24) begin
            alm_hh_d = alm_inc_s;
        end else begin
            alm_hh_d = alm_hh_q;
        end
        carry_d = up_clock24 && (clk_hh_q == 6'h23);
        if (clock_alarm) begin
            disp_s = clk_hh_q;
        end else begin
            disp_s = alm_hh_q;
        end
    end

    // Only a clock-hour step landing on the (pre-update) alarm hour triggers
    assign trigger_s = alarm_en && up_clock24 && (clk_inc_s == alm_hh_q);

    // Alarm FSM next-state and ring timeout counter
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            IDLE: begin
                if (!alarm_off && trigger_s) begin
                    state_d    = RING;
                    ring_cnt_d = {RING_W{1'b0}};
                end else begin
                    state_d    = IDLE;
                end
            end
            RING: begin
                if (alarm_off || !alarm_en || (ring_cnt_q == RING_LAST)) begin
                    state_d    = IDLE;
                    ring_cnt_d = {RING_W{1'b0}};
                end else begin
                    ring_cnt_d = ring_cnt_q + {{(RING_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d    = IDLE;
                ring_cnt_d = {RING_W{1'b0}};
            end
        endcase
    end

    // State registers
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            clk_hh_q   <= 6'h00;
            alm_hh_q   <= 6'h00;
            carry_q    <= 1'b0;
            state_q    <= IDLE;
            ring_cnt_q <= {RING_W{1'b0}};
        end else begin
            clk_hh_q   <= clk_hh_d;
            alm_hh_q   <= alm_hh_d;
            carry_q    <= carry_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign hh_tens    = disp_s[5:4];
    assign hh_units   = disp_s[3:0];
    assign carry_24   = carry_q;
    assign alarm_ring = (state_q == RING);

endmodule

// File: tb/tb_hh_counter24.sv
// Directed self-checking bench for hh_counter24 (RING_CYCLES shortened to 8).
module tb_hh_counter24;

    logic       ck = 1'b0;
    logic       reset = 1'b0;
    logic       up_clock24 = 1'b0;
    logic       up_alarm24 = 1'b0;
    logic       clock_alarm = 1'b1;
    logic       alarm_en = 1'b0;
    logic       alarm_off = 1'b0;
    logic [1:0] hh_tens;
    logic [3:0] hh_units;
    logic       carry_24;
    logic       alarm_ring;

    int checks = 0;
    int errors = 0;

    hh_counter24 #(.RING_CYCLES(8), .RING_W(16)) dut (
        .ck(ck), .reset(reset), .up_clock24(up_clock24), .up_alarm24(up_alarm24),
        .clock_alarm(clock_alarm), .alarm_en(alarm_en), .alarm_off(alarm_off),
        .hh_tens(hh_tens), .hh_units(hh_units), .carry_24(carry_24), .alarm_ring(alarm_ring)
    );

    always #5 ck = ~ck;

    // All stimulus and sampling happens 1 time unit after a rising edge
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic pulse(input logic c, input logic a);
        up_clock24 = c;
        up_alarm24 = a;
        tick();
        up_clock24 = 1'b0;
        up_alarm24 = 1'b0;
    endtask

    task automatic do_reset();
        up_clock24 = 1'b0; up_alarm24 = 1'b0; alarm_en = 1'b0; alarm_off = 1'b0;
        clock_alarm = 1'b1;
        reset = 1'b0;
        tick();
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({hh_tens, hh_units, carry_24, alarm_ring} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL reset_state: got tens=%0d units=%0d carry=%b ring=%b, want 0 0 0 0",
                     hh_tens, hh_units, carry_24, alarm_ring);
        end
    endtask

    task automatic test_count_wrap();
        int h = 0;
        int carry_seen = 0;
        logic [1:0] et;
        logic [3:0] eu;
        do_reset();
        clock_alarm = 1'b1;
        for (int i = 0; i < 25; i++) begin
            pulse(1'b1, 1'b0);
            h = (h + 1) % 24;
            et = 2'(h / 10);
            eu = 4'(h % 10);
            checks++;
            if ({hh_tens, hh_units} !== {et, eu}) begin
                errors++;
                $display("FAIL count_step%0d: got %0d%0d, want %0d%0d", i, hh_tens, hh_units, et, eu);
            end
            checks++;
            if (carry_24 !== (h == 0)) begin
                errors++;
                $display("FAIL carry_step%0d: got %b, want %b", i, carry_24, (h == 0));
            end
            if (carry_24 === 1'b1) carry_seen++;
        end
        checks++;
        if (carry_seen !== 1) begin
            errors++;
            $display("FAIL carry_count: got %0d carry cycles, want 1", carry_seen);
        end
        checks++;
        if ({hh_tens, hh_units} !== 6'h01) begin
            errors++;
            $display("FAIL count_final: got %0d%0d, want 01", hh_tens, hh_units);
        end
    endtask

    task automatic test_held_up();
        do_reset();
        up_clock24 = 1'b1;
        repeat (10) tick();
        up_clock24 = 1'b0;
        checks++;
        if ({hh_tens, hh_units} !== 6'h10) begin
            errors++;
            $display("FAIL held_clock: got %0d%0d, want 10", hh_tens, hh_units);
        end
        clock_alarm = 1'b0;
        #1;
        checks++;
        if ({hh_tens, hh_units} !== 6'h00) begin
            errors++;
            $display("FAIL held_alarm_reg: got %0d%0d, want 00", hh_tens, hh_units);
        end
        clock_alarm = 1'b1;
    endtask

    // Alarm at 07, clock at 06, then one clock pulse fires the ring
    task automatic setup_ring(input int alarm_h, input int clock_h);
        do_reset();
        repeat (alarm_h) pulse(1'b0, 1'b1);
        repeat (clock_h) pulse(1'b1, 1'b0);
        alarm_en = 1'b1;
        pulse(1'b1, 1'b0);
    endtask

    task automatic test_ring_timeout();
        int high_cycles = 0;
        setup_ring(7, 6);
        checks++;
        if (alarm_ring !== 1'b1) begin
            errors++;
            $display("FAIL ring_start: got %b, want 1", alarm_ring);
        end
        for (int i = 0; i < 20; i++) begin
            if (alarm_ring === 1'b1) high_cycles++;
            tick();
        end
        checks++;
        if (high_cycles !== 8) begin
            errors++;
            $display("FAIL ring_timeout: got %0d ring cycles, want 8", high_cycles);
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_ring_ack();
        setup_ring(7, 6);
        tick();
        tick();
        checks++;
        if (alarm_ring !== 1'b1) begin
            errors++;
            $display("FAIL ack_before: got %b, want 1", alarm_ring);
        end
        alarm_off = 1'b1;
        tick();
        alarm_off = 1'b0;
        checks++;
        if (alarm_ring !== 1'b0) begin
            errors++;
            $display("FAIL ack_stop: got %b, want 0", alarm_ring);
        end
        alarm_off = 1'b1;
        tick();
        alarm_off = 1'b0;
        tick();
        checks++;
        if ({alarm_ring, hh_tens, hh_units} !== 7'b0_00_0111) begin
            errors++;
            $display("FAIL ack_idle: got ring=%b hh=%0d%0d, want ring=0 hh=07",
                     alarm_ring, hh_tens, hh_units);
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_both_up();
        do_reset();
        repeat (23) pulse(1'b1, 1'b0);
        repeat (9) pulse(1'b0, 1'b1);
        alarm_en = 1'b1;
        pulse(1'b1, 1'b1);
        checks++;
        if ({hh_tens, hh_units, carry_24, alarm_ring} !== 8'b00_0000_1_0) begin
            errors++;
            $display("FAIL both_clock: got hh=%0d%0d carry=%b ring=%b, want 00 1 0",
                     hh_tens, hh_units, carry_24, alarm_ring);
        end
        clock_alarm = 1'b0;
        #1;
        checks++;
        if ({hh_tens, hh_units} !== 6'h10) begin
            errors++;
            $display("FAIL both_alarm: got %0d%0d, want 10", hh_tens, hh_units);
        end
        clock_alarm = 1'b1;
        tick();
        checks++;
        if ({carry_24, alarm_ring} !== 2'b00) begin
            errors++;
            $display("FAIL both_after: got carry=%b ring=%b, want 0 0", carry_24, alarm_ring);
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_reset_mid_ring();
        setup_ring(15, 14);
        tick();
        tick();
        checks++;
        if ({alarm_ring, hh_tens, hh_units} !== 7'b1_01_0101) begin
            errors++;
            $display("FAIL midring_pre: got ring=%b hh=%0d%0d, want 1 15", alarm_ring, hh_tens, hh_units);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({alarm_ring, carry_24, hh_tens, hh_units} !== 8'b0_0_00_0000) begin
            errors++;
            $display("FAIL midring_async_clk: got ring=%b carry=%b hh=%0d%0d, want 0 0 00",
                     alarm_ring, carry_24, hh_tens, hh_units);
        end
        clock_alarm = 1'b0;
        #1;
        checks++;
        if ({hh_tens, hh_units} !== 6'h00) begin
            errors++;
            $display("FAIL midring_async_alm: got %0d%0d, want 00", hh_tens, hh_units);
        end
        clock_alarm = 1'b1;
        alarm_en = 1'b0;
        tick();
        #2 reset = 1'b1;
        tick();
        pulse(1'b1, 1'b0);
        checks++;
        if ({hh_tens, hh_units, alarm_ring} !== 7'b00_0001_0) begin
            errors++;
            $display("FAIL midring_after: got hh=%0d%0d ring=%b, want 01 0", hh_tens, hh_units, alarm_ring);
        end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_held_up();
        test_ring_timeout();
        test_ring_ack();
        test_both_up();
        test_reset_mid_ring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
